// File: rtl/trdb_pkg.sv
// Shared types and sizes for the trace branch-map block.
// Live and snapshot state share one struct so they can be copied whole.
package trdb_pkg;

  localparam int BRANCH_MAP_LEN = 31;
  localparam int BRANCH_CNT_W   = 5;

  typedef struct packed {
    logic [BRANCH_MAP_LEN-1:0] map;
    logic [BRANCH_CNT_W-1:0]   branches;
  } branch_map_t;

  localparam branch_map_t BRANCH_MAP_CLEAR = '0;

endpackage

// File: rtl/trdb_branch_map.sv
// Accumulates resolved conditional branches into an E-Trace branch map
// (1 = not taken) and hands a stable snapshot to the packet emitter.
module trdb_branch_map
  import trdb_pkg::*;
#(
  parameter int MAP_LEN = BRANCH_MAP_LEN,
  parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               branch_i,
  input  logic               branch_taken_i,
  input  logic               flush_i,
  input  logic               snap_ready_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   branches_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic [MAP_LEN-1:0] snap_map_o,
  output logic [CNT_W-1:0]   snap_branches_o,
  output logic               snap_valid_o,
  output logic               overflow_o
);

  branch_map_t r_live;
  branch_map_t r_snap;
  logic        r_snap_valid;
  logic        r_overflow;

  branch_map_t        w_live_nxt;
  logic               w_full;
  logic               w_new_bit;
  logic [MAP_LEN-1:0] w_append_mask;
  logic               w_drop;
  logic               w_proto_err;

  assign w_full        = (r_live.branches == CNT_W'(MAP_LEN));
  assign w_new_bit     = ~branch_taken_i;
  assign w_append_mask = {{(MAP_LEN-1){1'b0}}, w_new_bit} << r_live.branches;

  // A flush clears first, so a same-cycle branch lands in bit 0 of the new map.
  always_comb begin
    w_live_nxt = r_live;
    if (flush_i) begin
      w_live_nxt = BRANCH_MAP_CLEAR;
      if (branch_i) begin
        w_live_nxt.map      = {{(MAP_LEN-1){1'b0}}, w_new_bit};
        w_live_nxt.branches = CNT_W'(1);
      end
    end else if (branch_i && !w_full) begin
      w_live_nxt.map      = r_live.map | w_append_mask;
      w_live_nxt.branches = r_live.branches + CNT_W'(1);
    end
  end

  assign w_drop      = branch_i && !flush_i && w_full;
  assign w_proto_err = flush_i && r_snap_valid && !snap_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live <= BRANCH_MAP_CLEAR;
    end else begin
      r_live <= w_live_nxt;
    end
  end

  // Snapshot handshake: snap_valid_o is held high until a cycle with
  // snap_ready_i=1, and drops on the following cycle. A flush in that same
  // cycle reloads the snapshot and keeps it valid; a flush while valid and
  // not ready overwrites the snapshot and is flagged on overflow_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_snap       <= BRANCH_MAP_CLEAR;
      r_snap_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= w_drop || w_proto_err;
      if (flush_i) begin
        r_snap       <= r_live;
        r_snap_valid <= 1'b1;
      end else if (r_snap_valid && snap_ready_i) begin
        r_snap_valid <= 1'b0;
      end
    end
  end

  assign map_o           = r_live.map;
  assign branches_o      = r_live.branches;
  assign is_full_o       = w_full;
  assign is_empty_o      = (r_live.branches == '0);
  assign snap_map_o      = r_snap.map;
  assign snap_branches_o = r_snap.branches;
  assign snap_valid_o    = r_snap_valid;
  assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Self-checking bench for trdb_branch_map: directed scenarios plus a random
// run checked against a queue-based model of the branch map.
module tb_trdb_branch_map;

  localparam int ML = 31;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          branch_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          snap_ready_i = 1'b0;
  logic [ML-1:0] map_o;
  logic [CW-1:0] branches_o;
  logic          is_full_o;
  logic          is_empty_o;
  logic [ML-1:0] snap_map_o;
  logic [CW-1:0] snap_branches_o;
  logic          snap_valid_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered list of recorded map bits, oldest first.
  bit live_q[$];
  bit snap_q[$];
  bit m_snap_valid;
  bit m_ovf;

  trdb_branch_map dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .branch_i       (branch_i),
    .branch_taken_i (branch_taken_i),
    .flush_i        (flush_i),
    .snap_ready_i   (snap_ready_i),
    .map_o          (map_o),
    .branches_o     (branches_o),
    .is_full_o      (is_full_o),
    .is_empty_o     (is_empty_o),
    .snap_map_o     (snap_map_o),
    .snap_branches_o(snap_branches_o),
    .snap_valid_o   (snap_valid_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [ML-1:0] q2map(input bit q[$]);
    logic [ML-1:0] m = '0;
    for (int i = 0; i < q.size(); i++) if (q[i]) m = m + (ML'(1) << i);
    return m;
  endfunction

  function automatic void model_step(input bit b, input bit t, input bit f, input bit r);
    m_ovf = 1'b0;
    if (f) begin
      if (m_snap_valid && !r) m_ovf = 1'b1;
      snap_q = live_q;
      m_snap_valid = 1'b1;
      live_q = {};
      if (b) live_q.push_back(!t);
    end else begin
      if (m_snap_valid && r) m_snap_valid = 1'b0;
      if (b) begin
        if (live_q.size() < ML) live_q.push_back(!t);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic step(input bit b, input bit t, input bit f, input bit r);
    branch_i = b; branch_taken_i = t; flush_i = f; snap_ready_i = r;
    @(posedge clk_i);
    model_step(b, t, f, r);
    @(negedge clk_i);
    branch_i = 1'b0; branch_taken_i = 1'b0; flush_i = 1'b0; snap_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    branch_i = 1'b0; branch_taken_i = 1'b0; flush_i = 1'b0; snap_ready_i = 1'b0;
    rst_ni = 1'b0;
    live_q = {}; snap_q = {}; m_snap_valid = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (map_o !== '0 || branches_o !== '0 || is_empty_o !== 1'b1 || is_full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_live: map=%h cnt=%0d empty=%b full=%b, required 0/0/1/0",
               map_o, branches_o, is_empty_o, is_full_o);
    end
    n_checks++;
    if (snap_map_o !== '0 || snap_branches_o !== '0 || snap_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_snap: smap=%h scnt=%0d svalid=%b ovf=%b, required all 0",
               snap_map_o, snap_branches_o, snap_valid_o, overflow_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (branches_o !== CW'(1) || snap_branches_o !== CW'(5) || snap_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: cnt=%0d scnt=%0d svalid=%b, required 1/5/1",
               branches_o, snap_branches_o, snap_valid_o);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Assert reset away from any clock edge; outputs must clear before the next edge.
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (map_o !== '0 || branches_o !== '0 || is_empty_o !== 1'b1 || snap_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: map=%h cnt=%0d empty=%b svalid=%b, required 0/0/1/0",
               map_o, branches_o, is_empty_o, snap_valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    live_q = {}; snap_q = {}; m_snap_valid = 1'b0; m_ovf = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_pattern();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (map_o !== ML'(0) || branches_o !== CW'(1) || is_empty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pattern_first: map=%h cnt=%0d empty=%b, required 0/1/0", map_o, branches_o, is_empty_o);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (map_o !== ML'(6) || branches_o !== CW'(4)) begin
      n_fail++;
      $display("FAIL pattern_tnnt: map=%h cnt=%0d, required 6/4", map_o, branches_o);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < ML; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (map_o !== 31'h7FFF_FFFF || branches_o !== CW'(31) || is_full_o !== 1'b1 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: map=%h cnt=%0d full=%b ovf=%b, required 7fffffff/31/1/0",
               map_o, branches_o, is_full_o, overflow_o);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b1 || map_o !== 31'h7FFF_FFFF || branches_o !== CW'(31)) begin
      n_fail++;
      $display("FAIL fill_overflow: ovf=%b map=%h cnt=%0d, required 1/7fffffff/31",
               overflow_o, map_o, branches_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || map_o !== 31'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL fill_ovf_pulse: ovf=%b map=%h, required 0/7fffffff", overflow_o, map_o);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || snap_branches_o !== CW'(31) || branches_o !== CW'(1) || map_o !== ML'(0)) begin
      n_fail++;
      $display("FAIL full_flush_branch: ovf=%b scnt=%0d cnt=%0d map=%h, required 0/31/1/0",
               overflow_o, snap_branches_o, branches_o, map_o);
    end
  endtask

  task automatic test_flush_branch();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (snap_map_o !== ML'(5) || snap_branches_o !== CW'(3) || snap_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_branch_snap: smap=%h scnt=%0d svalid=%b, required 5/3/1",
               snap_map_o, snap_branches_o, snap_valid_o);
    end
    n_checks++;
    if (map_o !== ML'(1) || branches_o !== CW'(1)) begin
      n_fail++;
      $display("FAIL flush_branch_live: map=%h cnt=%0d, required 1/1", map_o, branches_o);
    end
  endtask

  task automatic test_handshake();
    logic [ML-1:0] exp_map;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    exp_map = q2map(live_q);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (snap_valid_o !== 1'b1 || snap_map_o !== exp_map || snap_branches_o !== CW'(6)) begin
      n_fail++;
      $display("FAIL hs_flush: svalid=%b smap=%h scnt=%0d, required 1/%h/6",
               snap_valid_o, snap_map_o, snap_branches_o, exp_map);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_checks++;
      if (snap_valid_o !== 1'b1 || snap_map_o !== exp_map || snap_branches_o !== CW'(6)) begin
        n_fail++;
        $display("FAIL hs_hold%0d: svalid=%b smap=%h scnt=%0d, required 1/%h/6",
                 i, snap_valid_o, snap_map_o, snap_branches_o, exp_map);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (snap_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_release: svalid=%b, required 0", snap_valid_o);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (snap_valid_o !== 1'b1 || overflow_o !== 1'b0 || snap_branches_o !== CW'(0)) begin
      n_fail++;
      $display("FAIL hs_ready_flush: svalid=%b ovf=%b scnt=%0d, required 1/0/0",
               snap_valid_o, overflow_o, snap_branches_o);
    end
  endtask

  task automatic test_empty_double_flush();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (snap_branches_o !== CW'(0) || snap_valid_o !== 1'b1 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_flush: scnt=%0d svalid=%b ovf=%b, required 0/1/0",
               snap_branches_o, snap_valid_o, overflow_o);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (snap_branches_o !== CW'(0) || snap_valid_o !== 1'b1 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL double_flush: scnt=%0d svalid=%b ovf=%b, required 0/1/1",
               snap_branches_o, snap_valid_o, overflow_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || snap_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL double_flush_pulse: ovf=%b svalid=%b, required 0/1", overflow_o, snap_valid_o);
    end
  endtask

  task automatic test_random();
    bit b, t, f, r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 3) != 0);
      t = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 39) == 0);
      r = 1'($urandom_range(0, 1));
      step(b, t, f, r);
      n_checks++;
      if (map_o !== q2map(live_q) || branches_o !== CW'(live_q.size()) ||
          is_full_o !== (live_q.size() == ML) || is_empty_o !== (live_q.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_live[%0d]: map=%h cnt=%0d full=%b empty=%b, required %h/%0d",
                 i, map_o, branches_o, is_full_o, is_empty_o, q2map(live_q), live_q.size());
      end
      n_checks++;
      if (snap_map_o !== q2map(snap_q) || snap_branches_o !== CW'(snap_q.size()) ||
          snap_valid_o !== m_snap_valid || overflow_o !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_snap[%0d]: smap=%h scnt=%0d svalid=%b ovf=%b, required %h/%0d/%b/%b",
                 i, snap_map_o, snap_branches_o, snap_valid_o, overflow_o,
                 q2map(snap_q), snap_q.size(), m_snap_valid, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_fill_overflow();
    test_flush_branch();
    test_handshake();
    test_empty_double_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
